button_input: RTL and testbench
===============================

Name: button_input

Overview:
- Input-side I/O device for the game: samples the player's raw push-buttons, synchronizes and debounces each one, and turns each press into a single event.
- It is the receive-direction counterpart to the score display driver. The display drives pins from game state; this block turns pins into game-state events.
- The game FSM consumes events through a valid/ack handshake. There is a one-entry holding register, and presses that cannot be stored are counted as overruns.

Parameters:
- NUM_BUTTONS, 4, number of player buttons (2..8).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a level change is accepted (must be >= 1).
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (>= 2).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- buttons_raw  input  NUM_BUTTONS  raw button pins, active-high, asynchronous to clock.
- ack  input  1  consumer has taken the current event.
- press_valid  output  1  an event is held.
- press_id  output  3  index of the pressed button; valid only while press_valid is high.
- press_onehot  output  NUM_BUTTONS  one-hot form of press_id; all zeros when press_valid is low.
- buttons_level  output  NUM_BUTTONS  debounced level of each button.
- overrun  output  1  sticky flag: one or more presses were dropped.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-debounce or mid-handshake):
  - all synchronizer flops, debounce counters, buttons_level, press_valid, press_id, press_onehot and overrun go to 0.
  - When reset is released, any button already held high is debounced as a new press.
- Synchronizer: each bit passes through a SYNC_STAGES flop chain. Its output is the signal s.
- Debounce, per button:
  - counter width is clog2(DEBOUNCE_CYCLES+1).
  - In any cycle where s equals buttons_level, the counter goes to 0.
  - In any cycle where s differs, the counter increments.
  - When the counter would reach DEBOUNCE_CYCLES, buttons_level takes the value of s and the counter goes to 0.
  - A single cycle of bounce restarts the count. Releases are debounced identically.
- Press detection: a press is a 0->1 transition of buttons_level; releases generate no event.
  - Latency: if buttons_raw is first sampled high at edge E and stays high, press_valid is 1 after edge E + SYNC_STAGES + DEBOUNCE_CYCLES.
  - That is SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges counting E itself.
- Holding register:
  - A press is loaded when press_valid=0, or when press_valid=1 and ack=1 in the same cycle (replace).
  - Otherwise the press is dropped and overrun is set to 1.
  - ack with no accepted new press clears press_valid on the next edge.
  - ack while press_valid=0 is ignored.
- Simultaneous presses in one cycle: the lowest index wins. If any other press is also detected in that cycle, overrun is set.
- overrun is cleared only by reset.
- press_id is zero-extended; press_onehot is decoded from press_id and qualified by press_valid.
- The outputs are registered; no output depends combinationally on buttons_raw or ack.

Decomposition:
- Shared package button_pkg holds:
  - the max button count constant (8),
  - the press_id width (3),
  - the default debounce and sync constants,
  - a function for the counter width.
- Sub-module button_debounce (synchronizer, counter, stable level, rise pulse) is instantiated NUM_BUTTONS times.
- The top level contains the priority encoder, the holding register and overrun.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset state: assert reset for 3 cycles with buttons_raw=0 -> all outputs 0. Pulse reset mid-count -> counters and outputs return to 0 asynchronously.
- Clean press: buttons_raw=0010 held, first sampled at edge E -> press_valid=1, press_id=1, press_onehot=0010 after edge E+6. With ack=1 for one cycle, press_valid=0 after the next edge.
- Bounce rejection: button 2 toggles 1,1,1,0,1,1,1,1 -> no event until 4 consecutive synced highs after the glitch. Exactly one event, press_id=2.
- Release and repress: press 0, ack, release (stable 4), press 0 again -> two distinct events. Releasing alone produces no event, and buttons_level tracks 1->0->1.
- Overrun: press 3 without ack, then press 1 -> press_id stays 3 and overrun=1. ack in the same cycle as a later press of 0 -> press_id=0, press_valid stays 1.
- Simultaneous: buttons 1 and 3 rise on the same cycle -> press_id=1 and overrun=1.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants and helpers for the player push-button input path.
// Pure compile-time content: no logic, no latency.
// No flow control here; see button_input for the event handshake.
package button_pkg;

  // Upper bound on player buttons; press_id is sized to index this many.
  localparam int MAX_BUTTONS = 8;
  localparam int ID_W        = 3;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  // Counter must be able to hold DEBOUNCE_CYCLES itself.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one raw button; emits a one-cycle rise pulse on an accepted press.
// Latency: level/rise update SYNC_STAGES-1+DEBOUNCE_CYCLES edges after raw is first sampled.
// No backpressure: rise is a pulse and is not held.
//
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   raw          : raw button pin, asynchronous to clock
//   level        : debounced level
//   rise         : one-cycle pulse, registered alongside level going 0->1
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  // Counter value at which the next differing cycle completes the count.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= 1'b0;
      if (s == level) begin
        // Any agreeing cycle (including a one-cycle bounce) restarts the count.
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s;
        cnt   <= '0;
        rise  <= s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_input.sv
// Turns debounced button presses into single events held in a one-entry register.
// Latency: press_valid rises SYNC_STAGES+DEBOUNCE_CYCLES edges after raw is first sampled high.
// Backpressure: valid/ack; a press arriving while an unacked event is held is dropped and sets overrun.
//
// Ports:
//   clock, reset   : system clock, asynchronous active-high reset
//   buttons_raw    : raw button pins, active-high, asynchronous
//   ack            : consumer took the current event
//   press_valid    : an event is held
//   press_id       : index of the held press (zero-extended)
//   press_onehot   : one-hot of press_id, zero while press_valid is low
//   buttons_level  : debounced level of every button
//   overrun        : sticky, one or more presses were dropped
module button_input
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  input  logic                   ack,
  output logic                   press_valid,
  output logic [ID_W-1:0]        press_id,
  output logic [NUM_BUTTONS-1:0] press_onehot,
  output logic [NUM_BUTTONS-1:0] buttons_level,
  output logic                   overrun
);

  logic [NUM_BUTTONS-1:0] rise;
  logic [ID_W-1:0]        sel_id;
  logic [NUM_BUTTONS-1:0] sel_onehot;
  logic                   any_rise;
  logic                   multi_rise;
  logic                   load;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_debounce (
      .clock (clock),
      .reset (reset),
      .raw   (buttons_raw[i]),
      .level (buttons_level[i]),
      .rise  (rise[i])
    );
  end

  // Lowest index wins when several presses land in the same cycle.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (rise[i]) sel_id = ID_W'(i);
    end
  end

  assign sel_onehot = NUM_BUTTONS'(1) << sel_id;
  assign any_rise   = |rise;
  // Clearing the lowest set bit leaves something only if a second press exists.
  assign multi_rise = |(rise & (rise - NUM_BUTTONS'(1)));
  assign load       = any_rise && (!press_valid || ack);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      press_valid  <= 1'b0;
      press_id     <= '0;
      press_onehot <= '0;
      overrun      <= 1'b0;
    end else begin
      if (load) begin
        press_valid  <= 1'b1;
        press_id     <= sel_id;
        press_onehot <= sel_onehot;
      end else if (press_valid && ack) begin
        press_valid  <= 1'b0;
        press_onehot <= '0;
      end
      if ((any_rise && !load) || multi_rise) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_input.sv
module tb_button_input;

  localparam int NB = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] buttons_raw = '0;
  logic          ack = 1'b0;
  logic          press_valid;
  logic [2:0]    press_id;
  logic [NB-1:0] press_onehot;
  logic [NB-1:0] buttons_level;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  button_input #(
    .NUM_BUTTONS     (NB),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .buttons_raw   (buttons_raw),
    .ack           (ack),
    .press_valid   (press_valid),
    .press_id      (press_id),
    .press_onehot  (press_onehot),
    .buttons_level (buttons_level),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit after the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick(3);
    chk("rst_valid",   8'(press_valid),   8'h0);
    chk("rst_id",      8'(press_id),      8'h0);
    chk("rst_onehot",  8'(press_onehot),  8'h0);
    chk("rst_level",   8'(buttons_level), 8'h0);
    chk("rst_overrun", 8'(overrun),       8'h0);
    reset = 1'b0;
    tick(2);

    // Clean press of button 1: first sampled at edge E, valid after E+6
    buttons_raw = 4'b0010;
    tick(6);
    chk("clean_valid_early", 8'(press_valid),   8'h0);
    chk("clean_level",       8'(buttons_level), 8'h2);
    tick(1);
    chk("clean_valid",  8'(press_valid),  8'h1);
    chk("clean_id",     8'(press_id),     8'h1);
    chk("clean_onehot", 8'(press_onehot), 8'h2);
    do_ack();
    chk("clean_ack_valid",  8'(press_valid),  8'h0);
    chk("clean_ack_onehot", 8'(press_onehot), 8'h0);
    buttons_raw = 4'b0000;
    tick(8);
    chk("clean_rel_level", 8'(buttons_level), 8'h0);
    chk("clean_rel_valid", 8'(press_valid),   8'h0);

    // Bounce on button 2: 1,1,1,0 then steady 1 -> level at E9, valid at E10
    begin
      logic [7:0] pat;
      pat = 8'b1111_0111;
      for (int k = 0; k < 8; k++) begin
        buttons_raw = {1'b0, pat[k], 2'b00};
        tick(1);
      end
    end
    tick(2);
    chk("bounce_valid_early", 8'(press_valid),   8'h0);
    chk("bounce_level",       8'(buttons_level), 8'h4);
    tick(1);
    chk("bounce_valid", 8'(press_valid), 8'h1);
    chk("bounce_id",    8'(press_id),    8'h2);
    do_ack();
    tick(6);
    chk("bounce_single", 8'(press_valid), 8'h0);
    buttons_raw = 4'b0000;
    tick(8);

    // Release and repress button 0
    buttons_raw = 4'b0001;
    tick(7);
    chk("rep1_valid", 8'(press_valid),   8'h1);
    chk("rep1_id",    8'(press_id),      8'h0);
    chk("rep1_level", 8'(buttons_level), 8'h1);
    do_ack();
    buttons_raw = 4'b0000;
    tick(6);
    chk("rep_rel_level", 8'(buttons_level), 8'h0);
    chk("rep_rel_valid", 8'(press_valid),   8'h0);
    tick(2);
    buttons_raw = 4'b0001;
    tick(7);
    chk("rep2_valid",  8'(press_valid),   8'h1);
    chk("rep2_id",     8'(press_id),      8'h0);
    chk("rep2_level",  8'(buttons_level), 8'h1);
    chk("rep2_overrun", 8'(overrun),      8'h0);
    do_ack();
    buttons_raw = 4'b0000;
    tick(8);

    // Overrun: hold 3 unacked, then press 1
    buttons_raw = 4'b1000;
    tick(7);
    chk("ovr_first_id", 8'(press_id), 8'h3);
    buttons_raw = 4'b1010;
    tick(7);
    chk("ovr_valid",   8'(press_valid), 8'h1);
    chk("ovr_id",      8'(press_id),    8'h3);
    chk("ovr_overrun", 8'(overrun),     8'h1);
    // Press 0 with ack coinciding with its load edge: replace
    buttons_raw = 4'b1011;
    tick(6);
    do_ack();
    chk("repl_valid",  8'(press_valid),  8'h1);
    chk("repl_id",     8'(press_id),     8'h0);
    chk("repl_onehot", 8'(press_onehot), 8'h1);
    do_ack();
    buttons_raw = 4'b0000;
    tick(8);

    // Asynchronous reset mid-count; held button then debounces from scratch
    buttons_raw = 4'b0100;
    tick(4);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_overrun", 8'(overrun),       8'h0);
    chk("arst_level",   8'(buttons_level), 8'h0);
    chk("arst_valid",   8'(press_valid),   8'h0);
    tick(1);
    reset = 1'b0;
    tick(6);
    chk("arst_press_early", 8'(press_valid), 8'h0);
    tick(1);
    chk("arst_press_valid", 8'(press_valid), 8'h1);
    chk("arst_press_id",    8'(press_id),    8'h2);
    do_ack();
    buttons_raw = 4'b0000;
    tick(8);

    // Simultaneous presses of 1 and 3
    buttons_raw = 4'b1010;
    tick(7);
    chk("sim_valid",   8'(press_valid),  8'h1);
    chk("sim_id",      8'(press_id),     8'h1);
    chk("sim_onehot",  8'(press_onehot), 8'h2);
    chk("sim_overrun", 8'(overrun),      8'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
